// File: rtl/encoding_decoder.sv
// Receive-side decoder for the 3-bit Gray / one-hot code: one-register valid/ready stage
// with code-legality checking, Gray adjacency monitoring and error statistics.
module encoding_decoder #(
    parameter int USE_GRAY = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       data_out,
    output logic             out_err,
    output logic             adj_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             out_valid_q, out_valid_d;
    logic [2:0]       data_q, data_d;
    logic             out_err_q, out_err_d;
    logic             adj_err_q, adj_err_d;
    logic [2:0]       prev_q, prev_d;
    logic             hist_vld_q, hist_vld_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       accept;
    logic       err_event;
    logic [2:0] dec_val;
    logic       dec_err;
    logic       adj_hit;

    function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Returns {err, value}; all-zero is value 0, bit k alone is value k+1.
    function automatic logic [3:0] onehot_to_bin(input logic [6:0] c);
        logic [2:0] ones;
        logic [2:0] idx;
        ones = 3'd0;
        idx  = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (c[k]) begin
                ones = ones + 3'd1;
                idx  = 3'(k + 1);
            end
        end
        if (ones > 3'd1) begin
            return {1'b1, 3'd0};
        end
        return {1'b0, idx};
    endfunction

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign data_out   = data_q;
    assign out_err    = out_err_q;
    assign adj_err    = adj_err_q;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;

    always_comb begin
        dec_val = 3'd0;
        dec_err = 1'b0;
        adj_hit = 1'b0;
        if (USE_GRAY != 0) begin
            dec_val = gray_to_bin(code_in[2:0]);
            dec_err = |code_in[6:3];
            // A repeated code has popcount 0 and is flagged as well.
            adj_hit = !dec_err && hist_vld_q &&
                      (popcount3(code_in[2:0] ^ prev_q) != 2'd1);
        end else begin
            {dec_err, dec_val} = onehot_to_bin(code_in);
        end
    end

    assign err_event = accept && (dec_err || adj_hit);

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        out_err_d   = out_err_q;
        adj_err_d   = adj_err_q;
        prev_d      = prev_q;
        hist_vld_d  = hist_vld_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = dec_val;
            out_err_d   = dec_err;
            adj_err_d   = adj_hit;
            if ((USE_GRAY != 0) && !dec_err) begin
                prev_d     = code_in[2:0];
                hist_vld_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear first, then count, so an event coinciding with clr_err leaves a count of 1.
        if (clr_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
        if (err_event) begin
            sticky_d = 1'b1;
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= 3'd0;
            out_err_q   <= 1'b0;
            adj_err_q   <= 1'b0;
            prev_q      <= 3'd0;
            hist_vld_q  <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            out_err_q   <= out_err_d;
            adj_err_q   <= adj_err_d;
            prev_q      <= prev_d;
            hist_vld_q  <= hist_vld_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_encoding_decoder.sv
// Directed bench: a Gray-mode decoder (8-bit counter) and a one-hot decoder (2-bit counter).
module tb_encoding_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       g_in_valid, g_in_ready, g_out_valid, g_out_ready;
    logic [6:0] g_code;
    logic [2:0] g_data;
    logic       g_out_err, g_adj_err, g_sticky, g_clr;
    logic [7:0] g_cnt;

    logic       o_in_valid, o_in_ready, o_out_valid, o_out_ready;
    logic [6:0] o_code;
    logic [2:0] o_data;
    logic       o_out_err, o_adj_err, o_sticky, o_clr;
    logic [1:0] o_cnt;

    int checks = 0;
    int errors = 0;
    logic [6:0] gray_tab [8];

    encoding_decoder #(.USE_GRAY(1), .CNT_W(8)) u_gray (
        .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready),
        .code_in(g_code), .out_valid(g_out_valid), .out_ready(g_out_ready),
        .data_out(g_data), .out_err(g_out_err), .adj_err(g_adj_err),
        .err_sticky(g_sticky), .err_count(g_cnt), .clr_err(g_clr)
    );

    encoding_decoder #(.USE_GRAY(0), .CNT_W(2)) u_onehot (
        .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
        .code_in(o_code), .out_valid(o_out_valid), .out_ready(o_out_ready),
        .data_out(o_data), .out_err(o_out_err), .adj_err(o_adj_err),
        .err_sticky(o_sticky), .err_count(o_cnt), .clr_err(o_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        gray_tab[0] = 7'b0000000; gray_tab[1] = 7'b0000001;
        gray_tab[2] = 7'b0000011; gray_tab[3] = 7'b0000010;
        gray_tab[4] = 7'b0000110; gray_tab[5] = 7'b0000111;
        gray_tab[6] = 7'b0000101; gray_tab[7] = 7'b0000100;

        rst = 1'b1;
        g_in_valid = 1'b0; g_code = 7'd0; g_out_ready = 1'b1; g_clr = 1'b0;
        o_in_valid = 1'b0; o_code = 7'd0; o_out_ready = 1'b1; o_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", g_out_valid, 0);
        chk("rst_data", g_data, 0);
        chk("rst_out_err", g_out_err, 0);
        chk("rst_adj_err", g_adj_err, 0);
        chk("rst_sticky", g_sticky, 0);
        chk("rst_count", g_cnt, 0);
        chk("rst_in_ready", g_in_ready, 1);
        chk("rst_oh_count", o_cnt, 0);

        // Full Gray count sequence at full throughput
        g_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            g_code = gray_tab[i];
            tick();
            chk($sformatf("gray_seq_data%0d", i), g_data, i);
            chk($sformatf("gray_seq_valid%0d", i), g_out_valid, 1);
            chk($sformatf("gray_seq_adj%0d", i), g_adj_err, 0);
        end
        g_in_valid = 1'b0;
        chk("gray_seq_count", g_cnt, 0);
        tick();
        chk("gray_drain_valid", g_out_valid, 0);

        // Non-adjacent step, then an illegal word
        g_in_valid = 1'b1;
        g_code = 7'b0000000;
        tick();
        chk("adj_first_data", g_data, 0);
        chk("adj_first_adj", g_adj_err, 0);
        g_code = 7'b0000011;
        tick();
        chk("adj_jump_data", g_data, 2);
        chk("adj_jump_adj", g_adj_err, 1);
        chk("adj_jump_sticky", g_sticky, 1);
        chk("adj_jump_count", g_cnt, 1);
        g_code = 7'b1000001;
        tick();
        chk("illegal_err", g_out_err, 1);
        chk("illegal_data", g_data, 1);
        chk("illegal_adj", g_adj_err, 0);
        chk("illegal_count", g_cnt, 2);
        // prev must still be 011 after the illegal word, so 010 is adjacent
        g_code = 7'b0000010;
        tick();
        chk("prev_kept_adj", g_adj_err, 0);
        chk("prev_kept_data", g_data, 3);
        chk("prev_kept_count", g_cnt, 2);
        g_in_valid = 1'b0;

        g_clr = 1'b1;
        tick();
        g_clr = 1'b0;
        chk("clr_sticky", g_sticky, 0);
        chk("clr_count", g_cnt, 0);
        chk("clr_valid_drained", g_out_valid, 0);

        // Backpressure: output holds, input stalls
        g_out_ready = 1'b0;
        g_in_valid = 1'b1;
        g_code = 7'b0000110;
        tick();
        chk("bp_first_data", g_data, 4);
        chk("bp_first_valid", g_out_valid, 1);
        g_code = 7'b0000111;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_in_ready%0d", i), g_in_ready, 0);
            tick();
            chk($sformatf("bp_hold_data%0d", i), g_data, 4);
            chk($sformatf("bp_hold_valid%0d", i), g_out_valid, 1);
        end
        g_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", g_in_ready, 1);
        tick();
        chk("bp_swap_data", g_data, 5);
        chk("bp_swap_valid", g_out_valid, 1);
        chk("bp_swap_adj", g_adj_err, 0);
        g_in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", g_out_valid, 0);

        // One-hot decode
        o_in_valid = 1'b1;
        o_code = 7'b0000000;
        tick();
        chk("oh_zero_data", o_data, 0);
        chk("oh_zero_err", o_out_err, 0);
        o_code = 7'b0000001;
        tick();
        chk("oh_bit0_data", o_data, 1);
        chk("oh_bit0_err", o_out_err, 0);
        o_code = 7'b1000000;
        tick();
        chk("oh_bit6_data", o_data, 7);
        chk("oh_bit6_err", o_out_err, 0);
        o_code = 7'b0000101;
        tick();
        chk("oh_multi_data", o_data, 0);
        chk("oh_multi_err", o_out_err, 1);
        chk("oh_multi_adj", o_adj_err, 0);
        chk("oh_multi_count", o_cnt, 1);
        o_in_valid = 1'b0;
        o_clr = 1'b1;
        tick();
        o_clr = 1'b0;
        chk("oh_clr_count", o_cnt, 0);

        // Saturation of the 2-bit counter
        o_in_valid = 1'b1;
        o_code = 7'b0000011;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("sat_count%0d", i), o_cnt, (i > 3) ? 3 : i);
        end
        o_clr = 1'b1;
        tick();
        o_clr = 1'b0;
        o_in_valid = 1'b0;
        chk("sat_clr_event_count", o_cnt, 1);
        chk("sat_clr_event_sticky", o_sticky, 1);

        // Reset mid-stream: 010 after 111 is non-adjacent, counted once
        g_in_valid = 1'b1;
        g_code = 7'b0000010;
        tick();
        chk("mid_pre_adj", g_adj_err, 1);
        chk("mid_pre_count", g_cnt, 1);
        rst = 1'b1;
        g_code = 7'b1000000;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", g_out_valid, 0);
        chk("mid_rst_count", g_cnt, 0);
        chk("mid_rst_sticky", g_sticky, 0);
        chk("mid_rst_data", g_data, 0);
        // 101 is not adjacent to the old prev 010; history must be gone
        g_code = 7'b0000101;
        tick();
        g_in_valid = 1'b0;
        chk("mid_post_data", g_data, 6);
        chk("mid_post_adj", g_adj_err, 0);
        chk("mid_post_count", g_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
